// File: rtl/demux2_8_buffer.sv
// demux2_8_buffer: routes each byte to one of two channels, each buffered by its own valid/ready FIFO
module demux2_8_buffer #(
  parameter int LARGURA = 8,
  parameter int PROFUNDIDADE = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [LARGURA-1:0] Entrada,
  input  logic               EntradaValida,
  input  logic               Controle,
  output logic               EntradaPronta,
  output logic [LARGURA-1:0] Saida0,
  output logic               Saida0Valida,
  input  logic               Saida0Pronta,
  output logic [LARGURA-1:0] Saida1,
  output logic               Saida1Valida,
  input  logic               Saida1Pronta
);
  localparam int AW = $clog2(PROFUNDIDADE);
  localparam logic [AW:0] FULL = (AW+1)'(PROFUNDIDADE);
  logic [1:0][LARGURA-1:0] dout;
  logic [1:0] vld, full, pronta;
  logic push;
  assign pronta = {Saida1Pronta, Saida0Pronta};
  assign EntradaPronta = !full[Controle];
  assign push = EntradaValida && EntradaPronta;
  assign Saida0 = dout[0];
  assign Saida1 = dout[1];
  assign Saida0Valida = vld[0];
  assign Saida1Valida = vld[1];
  for (genvar c = 0; c < 2; c++) begin : ch
    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [AW-1:0] rp, wp;
    logic [AW:0] cnt;
    logic psh, pop;
    assign psh = push && (Controle == 1'(c));
    assign pop = vld[c] && pronta[c];
    assign vld[c] = cnt != '0;
    assign full[c] = cnt == FULL;
    assign dout[c] = mem[rp];
    // channel FIFO: storage, pointers and occupancy; reset wins over push/pop
    always_ff @(posedge Clock) begin
      if (Reset) begin
        rp <= '0;
        wp <= '0;
        cnt <= '0;
        for (int i = 0; i < PROFUNDIDADE; i++) mem[i] <= '0;
      end else begin
        if (psh) mem[wp] <= Entrada;
        if (psh) wp <= wp + AW'(1);
        if (pop) rp <= rp + AW'(1);
        cnt <= cnt + (AW+1)'(psh) - (AW+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_demux2_8_buffer.sv
// tb_demux2_8_buffer: table vectors, corner sequences and random traffic against a queue model
module tb_demux2_8_buffer;
  localparam int DEPTH = 2;
  logic Clock = 0, Reset = 1, EntradaValida = 0, Controle = 0, Saida0Pronta = 0, Saida1Pronta = 0;
  logic [7:0] Entrada = 0;
  logic EntradaPronta, Saida0Valida, Saida1Valida;
  logic [7:0] Saida0, Saida1;
  int pass_cnt = 0, total_cnt = 0;
  logic [7:0] q0[$], q1[$], popped1[$];

  demux2_8_buffer #(.LARGURA(8), .PROFUNDIDADE(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .Entrada(Entrada), .EntradaValida(EntradaValida),
    .Controle(Controle), .EntradaPronta(EntradaPronta),
    .Saida0(Saida0), .Saida0Valida(Saida0Valida), .Saida0Pronta(Saida0Pronta),
    .Saida1(Saida1), .Saida1Valida(Saida1Valida), .Saida1Pronta(Saida1Pronta)
  );

  always #5 Clock = !Clock;

  typedef struct {
    logic v, c;
    logic [7:0] d;
    logic r0, r1, rdy, v0, v1;
    logic [7:0] o0, o1;
  } vec_t;
  vec_t tv[4];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
  endtask

  task automatic setin(input logic v, input logic c, input logic [7:0] d, input logic r0, input logic r1);
    EntradaValida = v;
    Controle = c;
    Entrada = d;
    Saida0Pronta = r0;
    Saida1Pronta = r1;
    #1;
  endtask

  // compare current outputs against the model, take one edge, then update the model
  task automatic tick();
    logic erdy, p0, p1;
    erdy = (Controle ? q1.size() : q0.size()) < DEPTH;
    chk("ready", EntradaPronta, erdy);
    chk("valid0", Saida0Valida, q0.size() != 0);
    chk("valid1", Saida1Valida, q1.size() != 0);
    if (q0.size() != 0) chk("out0", Saida0, q0[0]);
    if (q1.size() != 0) chk("out1", Saida1, q1[0]);
    if ($isunknown({Saida0, Saida1})) chk("out_x", 1, 0);
    p0 = Saida0Pronta && q0.size() != 0;
    p1 = Saida1Pronta && q1.size() != 0;
    @(posedge Clock);
    if (Reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) popped1.push_back(q1.pop_front());
      if (EntradaValida && erdy) begin
        if (Controle) q1.push_back(Entrada);
        else q0.push_back(Entrada);
      end
    end
    @(negedge Clock);
  endtask

  task automatic check_reset_state();
    chk("rst_valid0", Saida0Valida, 0);
    chk("rst_valid1", Saida1Valida, 0);
    chk("rst_out0", Saida0, 8'h00);
    chk("rst_out1", Saida1, 8'h00);
    chk("rst_ready", EntradaPronta, 1);
  endtask

  initial begin
    tv[0] = '{v:1, c:0, d:8'hA5, r0:1, r1:1, rdy:1, v0:0, v1:0, o0:8'h00, o1:8'h00};
    tv[1] = '{v:1, c:1, d:8'h3C, r0:1, r1:1, rdy:1, v0:1, v1:0, o0:8'hA5, o1:8'h00};
    tv[2] = '{v:0, c:0, d:8'h00, r0:1, r1:1, rdy:1, v0:0, v1:1, o0:8'h00, o1:8'h3C};
    tv[3] = '{v:0, c:0, d:8'h00, r0:1, r1:1, rdy:1, v0:0, v1:0, o0:8'h00, o1:8'h00};
    @(negedge Clock);
    setin(0, 0, 0, 0, 0);
    tick();
    tick();
    Reset = 0;
    repeat (3) begin
      setin(0, 0, 0, 0, 0);
      check_reset_state();
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      setin(tv[i].v, tv[i].c, tv[i].d, tv[i].r0, tv[i].r1);
      chk($sformatf("tv%0d_ready", i), EntradaPronta, tv[i].rdy);
      chk($sformatf("tv%0d_valid0", i), Saida0Valida, tv[i].v0);
      chk($sformatf("tv%0d_valid1", i), Saida1Valida, tv[i].v1);
      if (tv[i].v0) chk($sformatf("tv%0d_out0", i), Saida0, tv[i].o0);
      if (tv[i].v1) chk($sformatf("tv%0d_out1", i), Saida1, tv[i].o1);
      tick();
    end
    setin(1, 0, 8'h01, 0, 0); tick();
    setin(1, 0, 8'h02, 0, 0); tick();
    setin(1, 0, 8'h03, 0, 0);
    chk("full_ready", EntradaPronta, 0);
    tick();
    setin(1, 1, 8'h03, 0, 0);
    chk("switch_ready", EntradaPronta, 1);
    setin(1, 0, 8'h03, 1, 0);
    chk("release_ready", EntradaPronta, 0);
    chk("release_head", Saida0, 8'h01);
    tick();
    setin(1, 0, 8'h03, 1, 0);
    chk("after_pop_ready", EntradaPronta, 1);
    chk("second_head", Saida0, 8'h02);
    tick();
    setin(0, 0, 0, 0, 0);
    chk("third_head", Saida0, 8'h03);
    chk("count1_valid", Saida0Valida, 1);
    setin(1, 0, 8'h55, 1, 0);
    tick();
    setin(0, 0, 0, 0, 0);
    chk("pushpop_head", Saida0, 8'h55);
    chk("pushpop_valid", Saida0Valida, 1);
    setin(0, 0, 0, 1, 0); tick();
    popped1.delete();
    for (int b = 8'h10; b <= 8'h17; b++) begin
      int n;
      logic acc;
      n = 0;
      acc = 0;
      while (!acc && n < 20) begin
        setin(1, 1, 8'(b), 0, 1'(($time / 10) % 2));
        acc = q1.size() < DEPTH;
        tick();
        n++;
      end
      if (!acc) chk("stream_timeout", 0, 1);
    end
    repeat (4) begin setin(0, 0, 0, 0, 1); tick(); end
    chk("stream_len", popped1.size(), 8);
    for (int i = 0; i < popped1.size() && i < 8; i++) chk($sformatf("stream%0d", i), popped1[i], 8'h10 + 8'(i));
    repeat (2) begin setin(1, 0, 8'hC0, 0, 0); tick(); end
    repeat (2) begin setin(1, 1, 8'hC1, 0, 0); tick(); end
    chk("both_full0", Saida0Valida && Saida1Valida, 1);
    setin(1, 0, 8'hEE, 0, 0);
    Reset = 1;
    tick();
    Reset = 0;
    setin(0, 0, 0, 0, 0);
    check_reset_state();
    repeat (3) begin setin(0, 0, 0, 1, 1); tick(); end
    repeat (300) begin
      setin(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
